dekatron_stepper: RTL and testbench

- Drive side of a single dekatron digit: generates the step/direction/reset signals that advance a dekatron ring (10-position one-hot, step on rising edge, Dir=0 increments, Dir=1 decrements, active-low reset to position 0).
- Accepts seek/increment/decrement/home commands over a valid/ready handshake.
- Tracks the tube position internally and verifies it against the synchronised cathode-sense vector after each command.
- Sits between the sequencer and each dekatron digit (IP/AP/data registers).

---
 rtl/dekatron_stepper_if.sv | 22 ++
 rtl/dekatron_stepper.sv | 233 +++++++++++++++++++++++
 tb/tb_dekatron_stepper.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dekatron_stepper_if.sv
// Command channel between the sequencer and a dekatron digit driver.
// Cmd_valid/Cmd_ready handshake; Cmd_op and Cmd_target ride with valid.
interface dekatron_stepper_if;
  logic       Cmd_valid;
  logic       Cmd_ready;
  logic [1:0] Cmd_op;
  logic [3:0] Cmd_target;

  modport master (
    output Cmd_valid,
    output Cmd_op,
    output Cmd_target,
    input  Cmd_ready
  );

  modport slave (
    input  Cmd_valid,
    input  Cmd_op,
    input  Cmd_target,
    output Cmd_ready
  );
endinterface

// File: rtl/dekatron_stepper.sv
// Drive side of one dekatron digit: step/dir/reset pulses, tracked Pos.
// Ports: Clk, Rst (async low), cmd (slave), StepOut, DirOut, RstOut,
//   Sense[9:0] (async one-hot), Pos[3:0], Busy, Done, Err.
module dekatron_stepper #(
  parameter int STEP_HI_CYC = 4,
  parameter int STEP_LO_CYC = 4,
  parameter int SETTLE_CYC  = 3,
  parameter int HOME_CYC    = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  dekatron_stepper_if.slave    cmd,
  output logic                 StepOut,
  output logic                 DirOut,
  output logic                 RstOut,
  input  logic [9:0]           Sense,
  output logic [3:0]           Pos,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err
);

  localparam int M1 =
    (STEP_HI_CYC > STEP_LO_CYC) ? STEP_HI_CYC : STEP_LO_CYC;
  localparam int M2 =
    (SETTLE_CYC > HOME_CYC) ? SETTLE_CYC : HOME_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [1:0] OP_SEEK = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_HOME = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOME,
    S_SETUP,
    S_PHI,
    S_PLO,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic [2:0]    nleft;
  logic          dir;
  logic          rdy;
  logic [9:0]    s1;
  logic [9:0]    s2;

  logic [4:0] fsum;
  logic [3:0] fwd;
  logic       sk_dir;
  logic [2:0] sk_n;
  logic       ld_dir;
  logic [2:0] ld_n;
  logic [3:0] sidx;
  logic       s_one;
  logic       s_match;
  logic       accept;
  logic [3:0] pos_nx;

  assign cmd.Cmd_ready = rdy;
  assign Busy   = (state != S_IDLE);
  assign accept = cmd.Cmd_valid & rdy & (state == S_IDLE);

  // Shortest way round the ring; a 5-step tie goes forward.
  always_comb begin
    fsum   = 5'd10 + {1'b0, cmd.Cmd_target} - {1'b0, Pos};
    fwd    = (fsum >= 5'd10) ? 4'(fsum - 5'd10) : fsum[3:0];
    sk_dir = (fwd > 4'd5);
    sk_n   = sk_dir ? 3'(4'd10 - fwd) : fwd[2:0];
  end

  always_comb begin
    ld_dir = 1'b0;
    ld_n   = 3'd0;
    unique case (cmd.Cmd_op)
      OP_SEEK: begin
        ld_dir = sk_dir;
        ld_n   = sk_n;
      end
      OP_INC: begin
        ld_dir = 1'b0;
        ld_n   = 3'd1;
      end
      OP_DEC: begin
        ld_dir = 1'b1;
        ld_n   = 3'd1;
      end
      default: begin
        ld_dir = 1'b0;
        ld_n   = 3'd0;
      end
    endcase
  end

  // Position after one step in the latched direction.
  always_comb begin
    if (dir)
      pos_nx = (Pos == 4'd0) ? 4'd9 : Pos - 4'd1;
    else
      pos_nx = (Pos == 4'd9) ? 4'd0 : Pos + 4'd1;
  end

  always_comb begin
    sidx = 4'd0;
    for (int i = 0; i < 10; i++)
      if (s2[i]) sidx = 4'(i);
    s_one   = $onehot(s2);
    s_match = (s2 == (10'd1 << Pos));
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= Sense;
      s2 <= s1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= S_IDLE;
      tmr     <= '0;
      nleft   <= '0;
      dir     <= 1'b0;
      rdy     <= 1'b0;
      StepOut <= 1'b0;
      DirOut  <= 1'b0;
      RstOut  <= 1'b0;
      Pos     <= 4'd0;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          rdy    <= 1'b1;
          RstOut <= 1'b1;
          if (accept) begin
            Err <= 1'b0;
            if (cmd.Cmd_op == OP_HOME) begin
              state  <= S_HOME;
              RstOut <= 1'b0;
              rdy    <= 1'b0;
              tmr    <= TW'(HOME_CYC - 1);
            end else if (cmd.Cmd_op == OP_SEEK &&
                         cmd.Cmd_target > 4'd9) begin
              Err  <= 1'b1;
              Done <= 1'b1;
            end else begin
              dir    <= ld_dir;
              DirOut <= ld_dir;
              nleft  <= ld_n;
              rdy    <= 1'b0;
              if (ld_n == 3'd0) begin
                state <= S_SETTLE;
                tmr   <= TW'(SETTLE_CYC - 1);
              end else begin
                state <= S_SETUP;
              end
            end
          end
        end
        S_HOME: begin
          if (tmr == '0) begin
            RstOut <= 1'b1;
            Pos    <= 4'd0;
            state  <= S_SETTLE;
            tmr    <= TW'(SETTLE_CYC - 1);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_SETUP: begin
          state   <= S_PHI;
          StepOut <= 1'b1;
          Pos     <= pos_nx;
          nleft   <= nleft - 3'd1;
          tmr     <= TW'(STEP_HI_CYC - 1);
        end
        S_PHI: begin
          if (tmr == '0) begin
            StepOut <= 1'b0;
            state   <= S_PLO;
            tmr     <= TW'(STEP_LO_CYC - 1);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_PLO: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (nleft != 3'd0) begin
            state   <= S_PHI;
            StepOut <= 1'b1;
            Pos     <= pos_nx;
            nleft   <= nleft - 3'd1;
            tmr     <= TW'(STEP_HI_CYC - 1);
          end else begin
            state <= S_SETTLE;
            tmr   <= TW'(SETTLE_CYC - 1);
          end
        end
        S_SETTLE: begin
          if (tmr == '0)
            state <= S_CHECK;
          else
            tmr <= tmr - 1'b1;
        end
        S_CHECK: begin
          Done  <= 1'b1;
          rdy   <= 1'b1;
          state <= S_IDLE;
          if (!(s_one && s_match))
            Err <= 1'b1;
          // A clean one-hot that disagrees means a lost/extra step.
          if (s_one && !s_match)
            Pos <= sidx;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dekatron_stepper.sv
// Directed bench for dekatron_stepper with a behavioural tube model.
// Tube can drop a step or blank its sense lines to provoke errors.
module tb_dekatron_stepper;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       StepOut;
  logic       DirOut;
  logic       RstOut;
  logic [9:0] Sense;
  logic [3:0] Pos;
  logic       Busy;
  logic       Done;
  logic       Err;

  always #5 Clk = ~Clk;

  dekatron_stepper_if cmd ();

  dekatron_stepper #(
    .STEP_HI_CYC(4),
    .STEP_LO_CYC(4),
    .SETTLE_CYC (3),
    .HOME_CYC   (8)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .cmd    (cmd),
    .StepOut(StepOut),
    .DirOut (DirOut),
    .RstOut (RstOut),
    .Sense  (Sense),
    .Pos    (Pos),
    .Busy   (Busy),
    .Done   (Done),
    .Err    (Err)
  );

  int   tpos    = 0;
  logic drop_en = 1'b0;
  logic dropped = 1'b0;
  logic zero_en = 1'b0;

  always @(posedge StepOut or negedge RstOut) begin
    if (!RstOut) begin
      tpos = 0;
    end else if (drop_en && !dropped) begin
      dropped = 1'b1;
    end else begin
      if (DirOut) tpos = (tpos == 0) ? 9 : tpos - 1;
      else        tpos = (tpos == 9) ? 0 : tpos + 1;
      if (!drop_en) dropped = 1'b0;
    end
  end

  assign Sense = zero_en ? 10'd0 : 10'(32'd1 << tpos);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int lat;
  int npul;
  int hi;
  int dir_or;
  int gap;
  int rstlo;
  int busy1;
  int pq[$];

  task automatic issue(input logic [1:0] op, input logic [3:0] tgt);
    int w;
    w = 0;
    @(negedge Clk);
    while (!cmd.Cmd_ready && w < 100) begin
      @(negedge Clk);
      w++;
    end
    cmd.Cmd_valid  = 1'b1;
    cmd.Cmd_op     = op;
    cmd.Cmd_target = tgt;
    @(posedge Clk);
    #1 cmd.Cmd_valid = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic [3:0] tgt);
    int k1;
    logic prev;
    issue(op, tgt);
    lat = -1; npul = 0; hi = 0; dir_or = 0;
    gap = -1; rstlo = 0; busy1 = -1; k1 = 0;
    prev = 1'b0;
    pq.delete();
    for (int k = 1; k <= 400; k++) begin
      @(negedge Clk);
      if (k == 1) busy1 = int'(Busy);
      if (StepOut) begin
        hi++;
        dir_or |= int'(DirOut);
        if (!prev) begin
          npul++;
          pq.push_back(int'(Pos));
          if (npul == 1) k1 = k;
          else if (npul == 2) gap = k - k1;
        end
      end
      prev = StepOut;
      if (!RstOut) rstlo++;
      if (Done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  int dseen;

  initial begin
    cmd.Cmd_valid  = 1'b0;
    cmd.Cmd_op     = 2'b00;
    cmd.Cmd_target = 4'd0;

    repeat (3) @(negedge Clk);
    chk("rst_step",  int'(StepOut), 0);
    chk("rst_rsto",  int'(RstOut), 0);
    chk("rst_pos",   int'(Pos), 0);
    chk("rst_err",   int'(Err), 0);
    chk("rst_ready", int'(cmd.Cmd_ready), 0);
    chk("rst_busy",  int'(Busy), 0);
    chk("rst_done",  int'(Done), 0);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rel_rsto",  int'(RstOut), 1);
    chk("rel_ready", int'(cmd.Cmd_ready), 1);

    run(2'b00, 4'd3);
    chk("s03_pul",  npul, 3);
    chk("s03_hi",   hi, 12);
    chk("s03_gap",  gap, 8);
    chk("s03_dir",  dir_or, 0);
    chk("s03_p0",   pq[0], 1);
    chk("s03_p1",   pq[1], 2);
    chk("s03_p2",   pq[2], 3);
    chk("s03_lat",  lat, 29);
    chk("s03_busy", busy1, 1);
    chk("s03_err",  int'(Err), 0);
    chk("s03_pos",  int'(Pos), 3);
    chk("s03_bsy2", int'(Busy), 0);

    run(2'b00, 4'd8);
    chk("s38_pul", npul, 5);
    chk("s38_dir", dir_or, 0);
    chk("s38_lat", lat, 45);
    chk("s38_pos", int'(Pos), 8);

    run(2'b00, 4'd2);
    chk("s82_pul", npul, 4);
    chk("s82_pos", int'(Pos), 2);

    run(2'b00, 4'd9);
    chk("s29_pul", npul, 3);
    chk("s29_dir", dir_or, 1);
    chk("s29_p0",  pq[0], 1);
    chk("s29_p1",  pq[1], 0);
    chk("s29_p2",  pq[2], 9);
    chk("s29_lat", lat, 29);
    chk("s29_pos", int'(Pos), 9);

    run(2'b01, 4'd0);
    chk("inc_pos", int'(Pos), 0);
    chk("inc_pul", npul, 1);
    chk("inc_lat", lat, 13);

    run(2'b10, 4'd0);
    chk("dec_pos", int'(Pos), 9);
    chk("dec_dir", dir_or, 1);
    chk("dec_pul", npul, 1);

    run(2'b00, 4'd9);
    chk("same_pul", npul, 0);
    chk("same_lat", lat, 4);
    chk("same_err", int'(Err), 0);

    run(2'b00, 4'd12);
    chk("ill_err", int'(Err), 1);
    chk("ill_lat", lat, 0);
    chk("ill_pul", npul, 0);
    chk("ill_pos", int'(Pos), 9);

    run(2'b00, 4'd0);
    chk("s90_pul", npul, 1);
    chk("s90_err", int'(Err), 0);
    chk("s90_pos", int'(Pos), 0);

    drop_en = 1'b1;
    run(2'b00, 4'd4);
    drop_en = 1'b0;
    chk("drop_pul", npul, 4);
    chk("drop_err", int'(Err), 1);
    chk("drop_pos", int'(Pos), 3);

    zero_en = 1'b1;
    run(2'b00, 4'd4);
    zero_en = 1'b0;
    chk("zero_pul", npul, 1);
    chk("zero_err", int'(Err), 1);
    chk("zero_pos", int'(Pos), 4);

    run(2'b01, 4'd0);
    chk("clr_err", int'(Err), 0);
    chk("clr_pos", int'(Pos), 5);

    run(2'b00, 4'd0);
    chk("s50_pul", npul, 5);
    chk("s50_pos", int'(Pos), 0);

    issue(2'b00, 4'd5);
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_step", int'(StepOut), 1);
    Rst = 1'b0;
    #1;
    chk("abort_step", int'(StepOut), 0);
    chk("abort_pos",  int'(Pos), 0);
    chk("abort_busy", int'(Busy), 0);
    dseen = 0;
    repeat (4) begin
      @(negedge Clk);
      dseen |= int'(Done);
    end
    chk("abort_done", dseen, 0);
    Rst = 1'b1;

    run(2'b01, 4'd0);
    chk("pre_home_pos", int'(Pos), 1);

    run(2'b11, 4'd0);
    chk("home_rstlo", rstlo, 8);
    chk("home_lat",   lat, 12);
    chk("home_pos",   int'(Pos), 0);
    chk("home_err",   int'(Err), 0);
    chk("home_pul",   npul, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
